hvac_actuator_ctrl: RTL and testbench

- Downstream consumer of the thermostat controller: takes its measured temperature (CurrentTemp) and setpoint (DesiredTemp) and drives the Heat/Cool/Fan relay outputs.
- Hysteresis prevents short-cycling around the setpoint; compressor-protection timers enforce a minimum run time and a minimum off time.
- One clock domain; an internal seconds prescaler times all dwell periods.

---
 rtl/hvac_actuator_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_hvac_actuator_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hvac_actuator_ctrl.sv
// hvac_actuator_ctrl
//   Turns the thermostat's CurrentTemp/DesiredTemp pair into Heat/Cool/Fan
//   relay drives. Hysteresis keeps the equipment from short-cycling around
//   the setpoint. Two compressor-protection dwells apply: a minimum run time
//   in HEAT/COOL and a minimum off time in LOCKOUT. LOCKOUT is also the state
//   entered from reset. A seconds prescaler times every dwell.
//
//   Optional feature macro: HVAC_FAN_OVERRUN_EN
//     defined   - HEAT/COOL exit through OVERRUN, which keeps the fan running
//                 for OVERRUN_SEC before LOCKOUT.
//     undefined - HEAT/COOL exit straight to LOCKOUT and OVERRUN_SEC is
//                 unused.
//
//   Interface: plain level inputs, sampled on every clk. There is no
//   valid/ready handshake. A setpoint or mode change is seen at the next
//   evaluation.
//   State is the FSM register itself, so checkers can bind to it directly.

module hvac_actuator_ctrl #(
  parameter int CLKS_PER_SEC = 100000000,
  parameter int HYST         = 2,
  parameter int MIN_ON_SEC   = 60,
  parameter int MIN_OFF_SEC  = 120,
  parameter int OVERRUN_SEC  = 30
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic [1:0] Mode,
  input  logic [7:0] CurrentTemp,
  input  logic [7:0] DesiredTemp,
  input  logic       FanOn,
  output logic       Heat,
  output logic       Cool,
  output logic       Fan,
  output logic [2:0] State,
  output logic       Lockout
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // ---------------------------------------------------------------------------
  if (CLKS_PER_SEC < 2) begin : g_bad_clks_per_sec
    $error("hvac_actuator_ctrl: CLKS_PER_SEC must be >= 2");
  end
  if (HYST < 1 || HYST > 255) begin : g_bad_hyst
    $error("hvac_actuator_ctrl: HYST must be in 1..255");
  end
  if (MIN_ON_SEC < 0 || MIN_ON_SEC > 65535) begin : g_bad_min_on
    $error("hvac_actuator_ctrl: MIN_ON_SEC must fit the 16-bit timer");
  end
  if (MIN_OFF_SEC < 0 || MIN_OFF_SEC > 65535) begin : g_bad_min_off
    $error("hvac_actuator_ctrl: MIN_OFF_SEC must fit the 16-bit timer");
  end
  if (OVERRUN_SEC < 0 || OVERRUN_SEC > 65535) begin : g_bad_overrun
    $error("hvac_actuator_ctrl: OVERRUN_SEC must fit the 16-bit timer");
  end

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int PW = (CLKS_PER_SEC > 2) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_SEC - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

  // Nine bits so that the setpoint plus the hysteresis never wraps past 255.
  localparam logic [8:0] HYST9 = 9'(HYST);

  localparam logic [15:0] ON_LOAD  = 16'(MIN_ON_SEC);
  localparam logic [15:0] OFF_LOAD = 16'(MIN_OFF_SEC);
`ifdef HVAC_FAN_OVERRUN_EN
  localparam logic [15:0] OVR_LOAD = 16'(OVERRUN_SEC);
`endif

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_HEAT    = 3'd1,
    ST_COOL    = 3'd2,
    ST_OVERRUN = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  // Where HEAT/COOL go once their run is finished.
`ifdef HVAC_FAN_OVERRUN_EN
  localparam state_t ST_POST_RUN = ST_OVERRUN;
`else
  localparam state_t ST_POST_RUN = ST_LOCKOUT;
`endif

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_t          state_q;
  state_t          state_d;
  logic [PW-1:0]   presc_q;
  logic [15:0]     timer_q;
  logic [15:0]     timer_dec;
  logic [15:0]     timer_load;
  logic            sec_tick;
  logic            timer_expired;
  logic            state_change;

  logic [8:0]      cur9;
  logic [8:0]      des9;
  logic            call_heat;
  logic            call_cool;
  logic            heat_done;
  logic            cool_done;

  logic            heat_d;
  logic            cool_d;
  logic            fan_d;
  logic            lockout_d;

  // ---------------------------------------------------------------------------
  // Temperature decisions
  // ---------------------------------------------------------------------------
  assign cur9 = {1'b0, CurrentTemp};
  assign des9 = {1'b0, DesiredTemp};

  // The two calls are mutually exclusive for HYST >= 1. The OFF state still
  // gives heat priority.
  assign call_heat = Mode[0] && ((cur9 + HYST9) <= des9);
  assign call_cool = Mode[1] && (cur9 >= (des9 + HYST9));

  // Once a mode is withdrawn, the run counts as satisfied. The minimum-on
  // timer still holds the equipment on until it expires.
  assign heat_done = (cur9 >= des9) || !Mode[0];
  assign cool_done = (cur9 <= des9) || !Mode[1];

  // ---------------------------------------------------------------------------
  // Dwell timing
  // ---------------------------------------------------------------------------
  assign sec_tick     = (presc_q == PRESC_LAST);
  assign state_change = (state_d != state_q);

  // This is the timer value that the coming edge will store.
  // Exits test it for zero, so an N-second dwell lasts exactly
  // N*CLKS_PER_SEC cycles from entry.
  assign timer_dec     = (sec_tick && (timer_q != 16'd0)) ? (timer_q - 16'd1) : timer_q;
  assign timer_expired = (timer_dec == 16'd0);

  // Prescaler: free-runs 0..CLKS_PER_SEC-1 and restarts on every state change
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      presc_q <= '0;
    end else if (state_change || sec_tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PRESC_ONE;
    end
  end

  // Dwell timer: loaded on state entry, otherwise counts seconds down to zero
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      timer_q <= OFF_LOAD;
    end else if (state_change) begin
      timer_q <= timer_load;
    end else begin
      timer_q <= timer_dec;
    end
  end

  // Dwell to load for the state being entered
  always_comb begin
    timer_load = 16'd0;
    case (state_d)
      ST_HEAT,
      ST_COOL:    timer_load = ON_LOAD;
`ifdef HVAC_FAN_OVERRUN_EN
      ST_OVERRUN: timer_load = OVR_LOAD;
`endif
      ST_LOCKOUT: timer_load = OFF_LOAD;
      default:    timer_load = 16'd0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // State register
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_LOCKOUT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: calls are only serviced from OFF; timed exits need timer==0
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF: begin
        if (call_heat) begin
          state_d = ST_HEAT;
        end else if (call_cool) begin
          state_d = ST_COOL;
        end
      end
      ST_HEAT: begin
        if (timer_expired && heat_done) begin
          state_d = ST_POST_RUN;
        end
      end
      ST_COOL: begin
        if (timer_expired && cool_done) begin
          state_d = ST_POST_RUN;
        end
      end
`ifdef HVAC_FAN_OVERRUN_EN
      ST_OVERRUN: begin
        if (timer_expired) begin
          state_d = ST_LOCKOUT;
        end
      end
`endif
      ST_LOCKOUT: begin
        if (timer_expired) begin
          state_d = ST_OFF;
        end
      end
      default: begin
        state_d = ST_LOCKOUT;
      end
    endcase
  end

  // Output decode from the next state, so the relays move on the same edge as State
  always_comb begin
    heat_d    = (state_d == ST_HEAT);
    cool_d    = (state_d == ST_COOL);
    lockout_d = (state_d == ST_LOCKOUT);
`ifdef HVAC_FAN_OVERRUN_EN
    fan_d     = heat_d || cool_d || (state_d == ST_OVERRUN) || FanOn;
`else
    fan_d     = heat_d || cool_d || FanOn;
`endif
  end

  // Relay and status registers. Reset drops every relay at once.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Heat    <= 1'b0;
      Cool    <= 1'b0;
      Fan     <= 1'b0;
      Lockout <= 1'b1;
    end else begin
      Heat    <= heat_d;
      Cool    <= cool_d;
      Fan     <= fan_d;
      Lockout <= lockout_d;
    end
  end

  assign State = state_q;

endmodule

// File: tb/tb_hvac_actuator_ctrl.sv
// tb_hvac_actuator_ctrl
//   Table of {inputs, wait, expected outputs} records applied in order from
//   reset release, followed by a hand-written asynchronous-reset sequence.
//   Expected words are pushed when a record is driven and popped at the
//   sample point. Exit-path expectations follow HVAC_FAN_OVERRUN_EN.

module tb_hvac_actuator_ctrl;

  localparam int CLKS_PER_SEC = 4;
  localparam int HYST         = 2;
  localparam int MIN_ON_SEC   = 3;
  localparam int MIN_OFF_SEC  = 2;
  localparam int OVERRUN_SEC  = 2;

  // Expected word layout: {State[2:0], Heat, Cool, Fan, Lockout}
  localparam logic [6:0] E_LOCK   = {3'd4, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [6:0] E_LOCK_F = {3'd4, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [6:0] E_OFF    = {3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam logic [6:0] E_OFF_F  = {3'd0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [6:0] E_HEAT   = {3'd1, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic [6:0] E_COOL   = {3'd2, 1'b0, 1'b1, 1'b1, 1'b0};
`ifdef HVAC_FAN_OVERRUN_EN
  // just after a run ends, and 8 cycles later
  localparam logic [6:0] E_POST   = {3'd3, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [6:0] E_POST8  = E_LOCK;
`else
  localparam logic [6:0] E_POST   = E_LOCK;
  localparam logic [6:0] E_POST8  = E_OFF;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       Reset_n;
  logic [1:0] Mode;
  logic [7:0] CurrentTemp;
  logic [7:0] DesiredTemp;
  logic       FanOn;
  logic       Heat;
  logic       Cool;
  logic       Fan;
  logic [2:0] State;
  logic       Lockout;

  always #5 clk = ~clk;

  hvac_actuator_ctrl #(
    .CLKS_PER_SEC(CLKS_PER_SEC),
    .HYST        (HYST),
    .MIN_ON_SEC  (MIN_ON_SEC),
    .MIN_OFF_SEC (MIN_OFF_SEC),
    .OVERRUN_SEC (OVERRUN_SEC)
  ) dut (
    .clk        (clk),
    .Reset_n    (Reset_n),
    .Mode       (Mode),
    .CurrentTemp(CurrentTemp),
    .DesiredTemp(DesiredTemp),
    .FanOn      (FanOn),
    .Heat       (Heat),
    .Cool       (Cool),
    .Fan        (Fan),
    .State      (State),
    .Lockout    (Lockout)
  );

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0] mode;
    logic [7:0] cur;
    logic [7:0] des;
    logic       fan_on;
    int         waitc;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input logic [1:0] m, input logic [7:0] c,
                                  input logic [7:0] d, input logic f,
                                  input int w, input logic [6:0] e);
    vec_t v;
    v.mode = m; v.cur = c; v.des = d; v.fan_on = f; v.waitc = w; v.exp = e;
    vecs.push_back(v);
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [6:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string nm);
    logic [6:0] got;
    logic [6:0] exp;
    got = {State, Heat, Cool, Fan, Lockout};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no expected entry queued, got state=%0d hcfl=%b", nm, got[6:4], got[3:0]);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: got state=%0d hcfl=%b, required state=%0d hcfl=%b",
                 nm, got[6:4], got[3:0], exp[6:4], exp[3:0]);
      end
    end
  endtask

  // Driver: apply inputs at a falling edge, queue the expectation, let
  // waitc rising edges pass, and sample at the following falling edge.
  task automatic step(input logic [1:0] m, input logic [7:0] c, input logic [7:0] d,
                      input logic f, input int w, input logic [6:0] e, input string nm);
    Mode        = m;
    CurrentTemp = c;
    DesiredTemp = d;
    FanOn       = f;
    exp_q.push_back(e);
    repeat (w) @(negedge clk);
    check(nm);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Heat run from reset. Heat is called throughout the reset lockout but is not serviced.
    add_vec(2'b01, 8'd70, 8'd75, 1'b0, 0, E_LOCK);   // reset state
    add_vec(2'b01, 8'd70, 8'd75, 1'b0, 7, E_LOCK);   // 7 edges in: still lockout
    add_vec(2'b01, 8'd70, 8'd75, 1'b0, 1, E_OFF);    // 8 edges: OFF
    add_vec(2'b01, 8'd70, 8'd75, 1'b0, 1, E_HEAT);   // next edge: HEAT (entry E)
    add_vec(2'b01, 8'd70, 8'd75, 1'b0, 4, E_HEAT);   // E+4
    add_vec(2'b01, 8'd75, 8'd75, 1'b0, 7, E_HEAT);   // satisfied, min-on holds to E+11
    add_vec(2'b01, 8'd75, 8'd75, 1'b0, 1, E_POST);   // E+12 exit
    add_vec(2'b01, 8'd75, 8'd75, 1'b0, 7, E_POST);   // E+19
    add_vec(2'b01, 8'd75, 8'd75, 1'b0, 1, E_POST8);  // E+20
    add_vec(2'b01, 8'd75, 8'd75, 1'b0, 7, E_POST8);  // E+27
    add_vec(2'b01, 8'd75, 8'd75, 1'b0, 1, E_OFF);    // E+28
    // Cool run in auto mode. 79 vs 78 is inside the hysteresis band.
    add_vec(2'b11, 8'd79, 8'd78, 1'b0, 3, E_OFF);
    add_vec(2'b11, 8'd80, 8'd78, 1'b0, 1, E_COOL);   // entry C
    add_vec(2'b11, 8'd80, 8'd78, 1'b0, 4, E_COOL);   // C+4
    add_vec(2'b11, 8'd78, 8'd78, 1'b0, 3, E_COOL);   // satisfied, C+7
    add_vec(2'b01, 8'd78, 8'd78, 1'b0, 4, E_COOL);   // mode change, still C+11
    add_vec(2'b01, 8'd78, 8'd78, 1'b0, 1, E_POST);   // C+12 exit
    add_vec(2'b01, 8'd78, 8'd78, 1'b0, 8, E_POST8);  // C+20
    add_vec(2'b01, 8'd78, 8'd78, 1'b0, 8, E_OFF);    // C+28
    // Boundaries: a 9-bit cool threshold of 256 is unreachable; no heat with Desired=1
    add_vec(2'b10, 8'd255, 8'd254, 1'b0, 3, E_OFF);
    add_vec(2'b11, 8'd255, 8'd254, 1'b0, 2, E_OFF);
    add_vec(2'b01, 8'd0,   8'd1,   1'b0, 3, E_OFF);
    add_vec(2'b00, 8'd0,   8'd100, 1'b1, 1, E_OFF_F);
    // Random: Mode=00 never calls, and Fan follows FanOn
    for (int i = 0; i < 4; i++) begin
      logic f;
      f = 1'($urandom_range(0, 1));
      add_vec(2'b00, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), f, 1,
              f ? E_OFF_F : E_OFF);
    end
    // Random: auto mode within +/-1 of the setpoint stays inside the dead band
    for (int i = 0; i < 4; i++) begin
      int d;
      d = $urandom_range(2, 253);
      add_vec(2'b11, 8'(d + $urandom_range(0, 2) - 1), 8'(d), 1'b0, 2, E_OFF);
    end
    add_vec(2'b01, 8'd0, 8'd2, 1'b0, 1, E_HEAT);     // Desired=2: heat called

    Reset_n     = 1'b0;
    Mode        = 2'b01;
    CurrentTemp = 8'd70;
    DesiredTemp = 8'd75;
    FanOn       = 1'b0;
    repeat (3) @(negedge clk);
    Reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].mode, vecs[i].cur, vecs[i].des, vecs[i].fan_on, vecs[i].waitc,
           vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Reset pulsed in the middle of a heat run: the relays drop before any clock edge
    #2;
    Reset_n = 1'b0;
    #1;
    exp_q.push_back(E_LOCK);
    check("async_reset_drop");
    FanOn = 1'b1;
    repeat (2) @(negedge clk);
    exp_q.push_back(E_LOCK);
    check("reset_held_fan_low");
    Reset_n = 1'b1;
    step(2'b01, 8'd0, 8'd2, 1'b1, 1, E_LOCK_F, "lockout_fanon_first");
    step(2'b01, 8'd0, 8'd2, 1'b1, 6, E_LOCK_F, "lockout_fanon_edge7");
    step(2'b01, 8'd0, 8'd2, 1'b1, 1, E_OFF_F,  "lockout_end_off");
    step(2'b01, 8'd0, 8'd2, 1'b1, 1, E_HEAT,   "heat_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Time limit guard
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got time=%0t required < 200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
